exc_commit_ctrl: RTL and testbench

//  Exception/interrupt commit controller at the WB stage; drives the CP0 exception interface and consumes its has_int/EPC outputs.

---
 rtl/exc_commit_ctrl.sv | 142 ++++++++++++++
 tb/tb_exc_commit_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/exc_commit_ctrl.sv
// Exception/interrupt commit controller at WB: chooses the winning cause,
// pulses exc/eret toward CP0, flushes the pipeline and holds a fetch redirect
// until fetch accepts it. Also counts taken exceptions, wrapping at 2^32.
module exc_commit_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hbfc00380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_bd,
  input  logic        wb_inst_adel,
  input  logic        wb_ri,
  input  logic        wb_ov,
  input  logic        wb_syscall,
  input  logic        wb_break,
  input  logic        wb_mem_adel,
  input  logic        wb_mem_ades,
  input  logic [31:0] wb_mem_addr,
  input  logic        wb_eret,
  input  logic        has_int,
  input  logic [31:0] cp0_epc,
  output logic        exc,
  output logic [4:0]  excode,
  output logic        bd,
  output logic [31:0] exc_pc,
  output logic [31:0] badvaddr,
  output logic        inst_adel,
  output logic        mem_adel,
  output logic        mem_ades,
  output logic        eret,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic [31:0] exc_count
);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_REDIRECT = 1'b1;

  logic [0:0]  r_state;
  logic        r_int_q;
  logic [31:0] r_redirect_pc;
  logic [31:0] r_exc_count;

  logic        w_active;
  logic        w_int;
  logic        w_exc;
  logic [4:0]  w_excode;
  logic        w_q_inst_adel;
  logic        w_q_mem_adel;
  logic        w_q_mem_ades;
  logic        w_eret;

  // WB causes are only looked at while no redirect is outstanding.
  assign w_active = wb_valid & (r_state == S_IDLE);
  // An interrupt must be seen on two consecutive cycles to be taken.
  assign w_int    = r_int_q & has_int;

  // Fixed-priority cause selection; only the winner's qualifier is raised.
  always_comb begin
    w_exc         = 1'b0;
    w_excode      = 5'h00;
    w_q_inst_adel = 1'b0;
    w_q_mem_adel  = 1'b0;
    w_q_mem_ades  = 1'b0;
    if (w_active) begin
      if (w_int) begin
        w_exc    = 1'b1;
        w_excode = 5'h00;
      end else if (wb_inst_adel) begin
        w_exc         = 1'b1;
        w_excode      = 5'h04;
        w_q_inst_adel = 1'b1;
      end else if (wb_ri) begin
        w_exc    = 1'b1;
        w_excode = 5'h0a;
      end else if (wb_ov) begin
        w_exc    = 1'b1;
        w_excode = 5'h0c;
      end else if (wb_syscall) begin
        w_exc    = 1'b1;
        w_excode = 5'h08;
      end else if (wb_break) begin
        w_exc    = 1'b1;
        w_excode = 5'h09;
      end else if (wb_mem_adel) begin
        w_exc        = 1'b1;
        w_excode     = 5'h04;
        w_q_mem_adel = 1'b1;
      end else if (wb_mem_ades) begin
        w_exc        = 1'b1;
        w_excode     = 5'h05;
        w_q_mem_ades = 1'b1;
      end
    end
  end

  // Any exception, interrupts included, suppresses a coincident eret.
  assign w_eret = w_active & wb_eret & ~w_exc;

  assign exc            = w_exc;
  assign excode         = w_excode;
  assign inst_adel      = w_q_inst_adel;
  assign mem_adel       = w_q_mem_adel;
  assign mem_ades       = w_q_mem_ades;
  assign eret           = w_eret;
  assign bd             = wb_bd;
  assign exc_pc         = wb_pc;
  assign badvaddr       = wb_mem_addr;
  assign redirect_valid = (r_state == S_REDIRECT);
  assign flush          = w_exc | w_eret | (r_state == S_REDIRECT);
  assign redirect_pc    = r_redirect_pc;
  assign exc_count      = r_exc_count;

  // Interrupt history, redirect FSM, redirect target and exception counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_int_q       <= 1'b0;
      r_redirect_pc <= 32'h0;
      r_exc_count   <= 32'h0;
    end else begin
      r_int_q     <= has_int;
      r_exc_count <= r_exc_count + {31'd0, w_exc};
      case (r_state)
        S_IDLE: begin
          if (w_exc | w_eret) begin
            r_redirect_pc <= w_exc ? EXC_VECTOR : cp0_epc;
            r_state       <= S_REDIRECT;
          end
        end
        S_REDIRECT: begin
          if (redirect_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Scoreboard bench for exc_commit_ctrl: stimulus pushes expected CP0 pulses
// and redirects; a negedge monitor pops and compares as the DUT presents them.
module tb_exc_commit_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wb_valid = 0, wb_bd = 0, wb_inst_adel = 0, wb_ri = 0, wb_ov = 0;
  logic        wb_syscall = 0, wb_break = 0, wb_mem_adel = 0, wb_mem_ades = 0;
  logic        wb_eret = 0, has_int = 0, redirect_ready = 0;
  logic [31:0] wb_pc = 0, wb_mem_addr = 0, cp0_epc = 0;
  logic        exc, bd, inst_adel, mem_adel, mem_ades, eret, flush, redirect_valid;
  logic [4:0]  excode;
  logic [31:0] exc_pc, badvaddr, redirect_pc, exc_count;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        exc;
    logic        eret;
    logic [4:0]  code;
    logic        ia;
    logic        ma;
    logic        ms;
    logic        bd;
    logic [31:0] pc;
    logic [31:0] bva;
  } ev_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] count;
  } rd_t;

  ev_t ev_q[$];
  rd_t rd_q[$];

  exc_commit_ctrl dut (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_bd(wb_bd),
    .wb_inst_adel(wb_inst_adel), .wb_ri(wb_ri), .wb_ov(wb_ov), .wb_syscall(wb_syscall),
    .wb_break(wb_break), .wb_mem_adel(wb_mem_adel), .wb_mem_ades(wb_mem_ades),
    .wb_mem_addr(wb_mem_addr), .wb_eret(wb_eret), .has_int(has_int), .cp0_epc(cp0_epc),
    .exc(exc), .excode(excode), .bd(bd), .exc_pc(exc_pc), .badvaddr(badvaddr),
    .inst_adel(inst_adel), .mem_adel(mem_adel), .mem_ades(mem_ades), .eret(eret),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  // Monitor: compare pulses and redirects against the scoreboard queues.
  always @(negedge clk) begin
    if (resetn) begin
      if (exc || eret) begin
        if (ev_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, exc, eret}, 32'd0);
        end else begin
          ev_t e;
          e = ev_q.pop_front();
          chk("exc", {31'd0, exc}, {31'd0, e.exc});
          chk("eret", {31'd0, eret}, {31'd0, e.eret});
          chk("excode", {27'd0, excode}, {27'd0, e.code});
          chk("qualifiers", {29'd0, inst_adel, mem_adel, mem_ades}, {29'd0, e.ia, e.ma, e.ms});
          chk("bd", {31'd0, bd}, {31'd0, e.bd});
          chk("exc_pc", exc_pc, e.pc);
          chk("badvaddr", badvaddr, e.bva);
          chk("flush_on_pulse", {31'd0, flush}, 32'd1);
          $display("pulse exc=%0b eret=%0b excode=%02h pc=%08h", exc, eret, excode, exc_pc);
        end
      end
      if (redirect_valid) begin
        chk("flush_in_redirect", {31'd0, flush}, 32'd1);
        if (rd_q.size() == 0) begin
          chk("unexpected_redirect", 32'd1, 32'd0);
        end else begin
          chk("redirect_pc", redirect_pc, rd_q[0].pc);
          chk("exc_count", exc_count, rd_q[0].count);
          if (redirect_ready) begin
            void'(rd_q.pop_front());
            $display("redirect accepted pc=%08h count=%0d", redirect_pc, exc_count);
          end
        end
      end
    end
  end

  task automatic clear_inputs();
    wb_valid = 0; wb_bd = 0; wb_inst_adel = 0; wb_ri = 0; wb_ov = 0;
    wb_syscall = 0; wb_break = 0; wb_mem_adel = 0; wb_mem_ades = 0; wb_eret = 0;
  endtask

  // Hold the currently set WB inputs for one cycle, then clear them.
  task automatic step();
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((ev_q.size() != 0 || rd_q.size() != 0) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, ev_q.size() + rd_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  function automatic ev_t mk_exc(input logic [4:0] c, input logic ia, input logic ma,
                                 input logic ms, input logic b, input logic [31:0] p,
                                 input logic [31:0] a);
    ev_t e;
    e = '{exc: 1'b1, eret: 1'b0, code: c, ia: ia, ma: ma, ms: ms, bd: b, pc: p, bva: a};
    return e;
  endfunction

  initial begin
    // Reset state
    #12;
    chk("rst_exc", {31'd0, exc}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_exc_count", exc_count, 32'd0);
    @(posedge clk); #1;
    resetn = 1;
    redirect_ready = 1;
    @(posedge clk); #1;

    // 1: overflow
    wb_valid = 1; wb_ov = 1; wb_pc = 32'h80001000; wb_mem_addr = 32'h00000010;
    ev_q.push_back(mk_exc(5'h0c, 0, 0, 0, 0, 32'h80001000, 32'h00000010));
    rd_q.push_back('{pc: 32'hbfc00380, count: 32'd1});
    step();
    drain("drain_t1");

    // 2: RI beats mem AdES, delay slot
    wb_valid = 1; wb_ri = 1; wb_mem_ades = 1; wb_bd = 1;
    wb_pc = 32'h80003008; wb_mem_addr = 32'h12345679;
    ev_q.push_back(mk_exc(5'h0a, 0, 0, 0, 1, 32'h80003008, 32'h12345679));
    rd_q.push_back('{pc: 32'hbfc00380, count: 32'd2});
    step();
    drain("drain_t2");

    // 3: eret to EPC, count unchanged
    wb_valid = 1; wb_eret = 1; cp0_epc = 32'h80002004; wb_pc = 32'h80000200; wb_mem_addr = 0;
    ev_q.push_back('{exc: 1'b0, eret: 1'b1, code: 5'h00, ia: 1'b0, ma: 1'b0, ms: 1'b0,
                     bd: 1'b0, pc: 32'h80000200, bva: 32'h0});
    rd_q.push_back('{pc: 32'h80002004, count: 32'd2});
    step();
    drain("drain_t3");

    // 4: interrupt on its second cycle beats eret
    has_int = 1;
    @(posedge clk); #1;
    wb_valid = 1; wb_eret = 1; wb_pc = 32'h80000300;
    ev_q.push_back(mk_exc(5'h00, 0, 0, 0, 0, 32'h80000300, 32'h0));
    rd_q.push_back('{pc: 32'hbfc00380, count: 32'd3});
    step();
    has_int = 0;
    drain("drain_t4");

    // 5: inst AdEL beats syscall; redirect held 3 cycles while syscall pulses
    redirect_ready = 0;
    wb_valid = 1; wb_inst_adel = 1; wb_syscall = 1; wb_pc = 32'h80000401;
    ev_q.push_back(mk_exc(5'h04, 1, 0, 0, 0, 32'h80000401, 32'h0));
    rd_q.push_back('{pc: 32'hbfc00380, count: 32'd4});
    step();
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1; wb_syscall = (i != 1); wb_pc = 32'h80000500 + 32'(i * 4);
      step();
    end
    redirect_ready = 1;
    drain("drain_t5");
    chk("t5_idle", {31'd0, redirect_valid}, 32'd0);

    // 6: reset while in REDIRECT
    redirect_ready = 0;
    wb_valid = 1; wb_break = 1; wb_pc = 32'h80000600;
    ev_q.push_back(mk_exc(5'h09, 0, 0, 0, 0, 32'h80000600, 32'h0));
    rd_q.push_back('{pc: 32'hbfc00380, count: 32'd5});
    step();
    @(posedge clk); #2;
    resetn = 0;
    #1;
    chk("rst_mid_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_mid_flush", {31'd0, flush}, 32'd0);
    chk("rst_mid_count", exc_count, 32'd0);
    chk("rst_mid_pending_ev", ev_q.size(), 32'd0);
    rd_q.delete();
    @(posedge clk); #1;
    resetn = 1;
    redirect_ready = 1;
    @(posedge clk); #1;
    chk("post_rst_idle", {31'd0, redirect_valid}, 32'd0);

    // 6b: counter wraps from all ones; mem AdEL beats mem AdES
    force dut.r_exc_count = 32'hffffffff;
    @(posedge clk); #1;
    release dut.r_exc_count;
    chk("forced_count", exc_count, 32'hffffffff);
    wb_valid = 1; wb_mem_adel = 1; wb_mem_ades = 1; wb_pc = 32'h80000700; wb_mem_addr = 32'h00000003;
    ev_q.push_back(mk_exc(5'h04, 0, 1, 0, 0, 32'h80000700, 32'h00000003));
    rd_q.push_back('{pc: 32'hbfc00380, count: 32'd0});
    step();
    drain("drain_t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
